// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load/mul-div writeback.
// Tracks pending writes in a scoreboard and raises a decode stall on hits.
`timescale 1ns/1ps
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [IDX_W-1:0]      a_index,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [IDX_W-1:0]      b_index,
  input  logic [DATA_W-1:0]     b_data,
  output logic                  wr_enable,
  output logic [IDX_W-1:0]      wr_index,
  output logic [DATA_W-1:0]     wr_data,
  input  logic                  issue_valid,
  input  logic [IDX_W-1:0]      issue_index,
  input  logic [IDX_W-1:0]      q_rs_index,
  input  logic [IDX_W-1:0]      q_rt_index,
  output logic                  stall,
  output logic [2**IDX_W-1:0]   busy_mask,
  output logic [CNT_W-1:0]      conflict_count
);

  localparam int NREG = 2**IDX_W;
  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  logic              r_full_a;
  logic              r_full_b;
  logic [IDX_W-1:0]  r_idx_a;
  logic [IDX_W-1:0]  r_idx_b;
  logic [DATA_W-1:0] r_data_a;
  logic [DATA_W-1:0] r_data_b;
  logic              r_last_b;
  logic [NREG-1:0]   r_busy;
  logic [CNT_W-1:0]  r_cnt;

  logic            w_grant_a;
  logic            w_grant_b;
  logic            w_load_a;
  logic            w_load_b;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  // On a tie the source that did not win last time gets the port.
  assign w_grant_a = r_full_a & (~r_full_b | r_last_b);
  assign w_grant_b = r_full_b & (~r_full_a | ~r_last_b);

  assign a_ready = reset_n & (~r_full_a | w_grant_a);
  assign b_ready = reset_n & (~r_full_b | w_grant_b);

  assign w_load_a = a_valid & a_ready & (a_index != '0);
  assign w_load_b = b_valid & b_ready & (b_index != '0);

  always_comb begin
    wr_enable = w_grant_a | w_grant_b;
    wr_index  = '0;
    wr_data   = '0;
    unique case (1'b1)
      w_grant_a: begin
        wr_index = r_idx_a;
        wr_data  = r_data_a;
      end
      w_grant_b: begin
        wr_index = r_idx_b;
        wr_data  = r_data_b;
      end
      default: ;
    endcase
  end

  assign w_set = (issue_valid && issue_index != '0) ? (ONE << issue_index) : '0;
  assign w_clr = wr_enable ? (ONE << wr_index) : '0;

  assign stall = r_busy[q_rs_index] | r_busy[q_rt_index]
               | (issue_valid & r_busy[issue_index]);

  assign busy_mask      = r_busy;
  assign conflict_count = r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full_a <= 1'b0;
      r_full_b <= 1'b0;
      r_idx_a  <= '0;
      r_idx_b  <= '0;
      r_data_a <= '0;
      r_data_b <= '0;
      r_last_b <= 1'b1;
      r_busy   <= '0;
      r_cnt    <= '0;
    end else begin
      r_full_a <= w_load_a | (r_full_a & ~w_grant_a);
      r_full_b <= w_load_b | (r_full_b & ~w_grant_b);
      if (w_load_a) begin
        r_idx_a  <= a_index;
        r_data_a <= a_data;
      end
      if (w_load_b) begin
        r_idx_b  <= b_index;
        r_data_b <= b_data;
      end
      if (wr_enable)
        r_last_b <= w_grant_b;
      // A reservation issued alongside the retiring write keeps the bit set.
      r_busy <= (r_busy & ~w_clr) | w_set;
      if (r_full_a && r_full_b && !(&r_cnt))
        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
